// File: rtl/vnarrow_merge_pkg.sv
// Shared vALU definitions for the narrowing merge stage.
//   SEW8..SEW64    : element-width codes carried on in_sew/out_sew
//   merge_state_e  : pairing FSM states
package vnarrow_merge_pkg;

  localparam logic [1:0] SEW8  = 2'd0;
  localparam logic [1:0] SEW16 = 2'd1;
  localparam logic [1:0] SEW32 = 2'd2;
  localparam logic [1:0] SEW64 = 2'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing held
    HOLD  = 2'd1,  // low half held, waiting for its high half
    FLUSH = 2'd2   // held low half queued for emission next cycle
  } merge_state_e;

endpackage

// File: rtl/vnarrow_merge_if.sv
// Bus between the narrowing stage, the merge block and VRF writeback.
//   in_*  : narrowed half-word stream (in_valid, in_hi, in_vec, in_be,
//           in_sew, in_addr, in_last, in_flush)
//   out_* : merged registered word (out_valid, out_vec, out_be, out_sew,
//           out_addr) plus busy
//   slave  : the merge block
//   master : the surrounding stage / bench
interface vnarrow_merge_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);

  logic                  in_valid;
  logic                  in_hi;
  logic [DATA_WIDTH-1:0] in_vec;
  logic [BE_WIDTH-1:0]   in_be;
  logic [SEW_WIDTH-1:0]  in_sew;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_last;
  logic                  in_flush;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_vec;
  logic [BE_WIDTH-1:0]   out_be;
  logic [SEW_WIDTH-1:0]  out_sew;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  busy;

  modport slave (
    input  in_valid, in_hi, in_vec, in_be, in_sew, in_addr, in_last, in_flush,
    output out_valid, out_vec, out_be, out_sew, out_addr, busy
  );

  modport master (
    output in_valid, in_hi, in_vec, in_be, in_sew, in_addr, in_last, in_flush,
    input  out_valid, out_vec, out_be, out_sew, out_addr, busy
  );

endinterface

// File: rtl/vnarrow_merge_hold.sv
// Hold-register bank for the held low half-word of a pair.
//   clk, rst        : clock, synchronous active-high reset
//   capture         : load d_* (wins over clear)
//   clear           : zero the bank
//   d_lo/be/sew/addr: low-half data, byte-enables, SEW, address to hold
//   q_lo/be/sew/addr: held values
module vnarrow_merge_hold #(
  parameter int unsigned HALF_WIDTH = 32,
  parameter int unsigned HBE_WIDTH  = 4,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  clear,
  input  logic [HALF_WIDTH-1:0] d_lo,
  input  logic [HBE_WIDTH-1:0]  d_be,
  input  logic [SEW_WIDTH-1:0]  d_sew,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic [HALF_WIDTH-1:0] q_lo,
  output logic [HBE_WIDTH-1:0]  q_be,
  output logic [SEW_WIDTH-1:0]  q_sew,
  output logic [ADDR_WIDTH-1:0] q_addr
);

  // Capture beats clear: a restart after a gap emits the old half and
  // loads the new one in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_lo   <= '0;
      q_be   <= '0;
      q_sew  <= '0;
      q_addr <= '0;
    end else if (capture) begin
      q_lo   <= d_lo;
      q_be   <= d_be;
      q_sew  <= d_sew;
      q_addr <= d_addr;
    end else if (clear) begin
      q_lo   <= '0;
      q_be   <= '0;
      q_sew  <= '0;
      q_addr <= '0;
    end
  end

endmodule

// File: rtl/vnarrow_merge.sv
// Pairs a narrowed low half-word with the following high half-word into one
// full VRF word, merging byte-enables. A lone half is written as a partial
// word at gaps, instruction end or flush. All outputs registered, 1-cycle
// latency.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vnarrow_merge_if.slave (in_* half stream, out_* merged word,
//              busy = a half is held or a flush is queued)
module vnarrow_merge
  import vnarrow_merge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HALF_WIDTH = DATA_WIDTH / 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic           clk,
  input  logic           rst,
  vnarrow_merge_if.slave bus
);

  localparam int unsigned HBE_WIDTH = BE_WIDTH / 2;

  merge_state_e state, state_n;

  logic                  capture, clear;
  logic [HALF_WIDTH-1:0] h_lo;
  logic [HBE_WIDTH-1:0]  h_be;
  logic [SEW_WIDTH-1:0]  h_sew;
  logic [ADDR_WIDTH-1:0] h_addr;

  logic [HALF_WIDTH-1:0] lo_vec, hi_vec;
  logic [HBE_WIDTH-1:0]  lo_be, hi_be;

  logic                  emit_valid;
  logic [DATA_WIDTH-1:0] emit_vec;
  logic [BE_WIDTH-1:0]   emit_be;
  logic [SEW_WIDTH-1:0]  emit_sew;
  logic [ADDR_WIDTH-1:0] emit_addr;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_vec_q;
  logic [BE_WIDTH-1:0]   out_be_q;
  logic [SEW_WIDTH-1:0]  out_sew_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;

  assign lo_vec = bus.in_vec[HALF_WIDTH-1:0];
  assign hi_vec = bus.in_vec[DATA_WIDTH-1:HALF_WIDTH];
  assign lo_be  = bus.in_be[HBE_WIDTH-1:0];
  assign hi_be  = bus.in_be[BE_WIDTH-1:HBE_WIDTH];

  vnarrow_merge_hold #(
    .HALF_WIDTH (HALF_WIDTH),
    .HBE_WIDTH  (HBE_WIDTH),
    .SEW_WIDTH  (SEW_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .clear   (clear),
    .d_lo    (lo_vec),
    .d_be    (lo_be),
    .d_sew   (bus.in_sew),
    .d_addr  (bus.in_addr),
    .q_lo    (h_lo),
    .q_be    (h_be),
    .q_sew   (h_sew),
    .q_addr  (h_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    capture    = 1'b0;
    clear      = 1'b0;
    emit_valid = 1'b0;
    emit_vec   = '0;
    emit_be    = '0;
    emit_sew   = '0;
    emit_addr  = '0;
    unique case (state)
      EMPTY: begin
        if (bus.in_valid) begin
          if (bus.in_hi) begin
            // orphan high half: written alone with its own addr/sew
            emit_valid = 1'b1;
            emit_vec   = {hi_vec, {HALF_WIDTH{1'b0}}};
            emit_be    = {hi_be, {HBE_WIDTH{1'b0}}};
            emit_sew   = bus.in_sew;
            emit_addr  = bus.in_addr;
          end else if (bus.in_last || bus.in_flush) begin
            emit_valid = 1'b1;
            emit_vec   = {{HALF_WIDTH{1'b0}}, lo_vec};
            emit_be    = {{HBE_WIDTH{1'b0}}, lo_be};
            emit_sew   = bus.in_sew;
            emit_addr  = bus.in_addr;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.in_valid && bus.in_hi) begin
          emit_valid = 1'b1;
          emit_vec   = {hi_vec, h_lo};
          emit_be    = {hi_be, h_be};
          emit_sew   = h_sew;
          emit_addr  = h_addr;
          clear      = 1'b1;
          state_n    = EMPTY;
        end else if (bus.in_valid) begin
          // Restart after a gap: the old half goes out now, so a new low
          // half that must also go out (last/flush) is queued via FLUSH.
          emit_valid = 1'b1;
          emit_vec   = {{HALF_WIDTH{1'b0}}, h_lo};
          emit_be    = {{HBE_WIDTH{1'b0}}, h_be};
          emit_sew   = h_sew;
          emit_addr  = h_addr;
          capture    = 1'b1;
          state_n    = (bus.in_last || bus.in_flush) ? FLUSH : HOLD;
        end else if (bus.in_flush) begin
          emit_valid = 1'b1;
          emit_vec   = {{HALF_WIDTH{1'b0}}, h_lo};
          emit_be    = {{HBE_WIDTH{1'b0}}, h_be};
          emit_sew   = h_sew;
          emit_addr  = h_addr;
          clear      = 1'b1;
          state_n    = EMPTY;
        end
      end
      FLUSH: begin
        emit_valid = 1'b1;
        emit_vec   = {{HALF_WIDTH{1'b0}}, h_lo};
        emit_be    = {{HBE_WIDTH{1'b0}}, h_be};
        emit_sew   = h_sew;
        emit_addr  = h_addr;
        clear      = 1'b1;
        state_n    = EMPTY;
      end
      default: begin
        clear   = 1'b1;
        state_n = EMPTY;
      end
    endcase
  end

  // Outputs reload every cycle so idle cycles present zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_be_q    <= '0;
      out_sew_q   <= '0;
      out_addr_q  <= '0;
    end else begin
      out_valid_q <= emit_valid;
      out_vec_q   <= emit_vec;
      out_be_q    <= emit_be;
      out_sew_q   <= emit_sew;
      out_addr_q  <= emit_addr;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_be    = out_be_q;
  assign bus.out_sew   = out_sew_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.busy      = (state != EMPTY);

endmodule

// File: tb/tb_vnarrow_merge.sv
// Table-driven bench for vnarrow_merge: each row drives one cycle of
// inputs and states the registered outputs and busy expected just after
// that clock edge.
module tb_vnarrow_merge;
  import vnarrow_merge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vnarrow_merge_if bus ();

  vnarrow_merge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, valid, hi;
    logic [63:0] vec;
    logic [7:0]  be;
    logic [1:0]  sew;
    logic [31:0] addr;
    logic        last, flush;
    logic        e_valid;
    logic [63:0] e_vec;
    logic [7:0]  e_be;
    logic [1:0]  e_sew;
    logic [31:0] e_addr;
    logic        e_busy;
  } row_t;

  row_t tbl[$];
  row_t seq[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  // upstream guarantee: no valid input the cycle after in_last
  logic prev_last = 1'b0;
  always @(posedge clk) begin
    assert (!(prev_last && bus.in_valid && !rst))
      else $error("protocol: in_valid the cycle after in_last");
    prev_last <= bus.in_valid && bus.in_last && !rst;
  end

  function automatic row_t mk(
    input logic r, v, h, input logic [63:0] vec, input logic [7:0] be,
    input logic [1:0] sew, input logic [31:0] addr, input logic last, fl,
    input logic ev, input logic [63:0] evec, input logic [7:0] ebe,
    input logic [1:0] esew, input logic [31:0] eaddr, input logic ebusy);
    row_t t;
    t.rst = r; t.valid = v; t.hi = h; t.vec = vec; t.be = be; t.sew = sew;
    t.addr = addr; t.last = last; t.flush = fl;
    t.e_valid = ev; t.e_vec = evec; t.e_be = ebe; t.e_sew = esew;
    t.e_addr = eaddr; t.e_busy = ebusy;
    return t;
  endfunction

  function automatic row_t idle(input logic ebusy);
    return mk(0,0,0, 64'h0, 8'h00, SEW8, 32'h0, 0,0, 0, 64'h0, 8'h00, SEW8, 32'h0, ebusy);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input string tag, input row_t t);
    rst          = t.rst;
    bus.in_valid = t.valid;
    bus.in_hi    = t.hi;
    bus.in_vec   = t.vec;
    bus.in_be    = t.be;
    bus.in_sew   = t.sew;
    bus.in_addr  = t.addr;
    bus.in_last  = t.last;
    bus.in_flush = t.flush;
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'(t.e_valid));
    check({tag, " out_vec"},   bus.out_vec,        t.e_vec);
    check({tag, " out_be"},    64'(bus.out_be),    64'(t.e_be));
    check({tag, " out_sew"},   64'(bus.out_sew),   64'(t.e_sew));
    check({tag, " out_addr"},  64'(bus.out_addr),  64'(t.e_addr));
    check({tag, " busy"},      64'(bus.busy),      64'(t.e_busy));
  endtask

  initial begin
    // reset
    tbl.push_back(mk(1,0,0, 64'h0, 8'h00, SEW8, 32'h0, 0,0, 0, 64'h0, 8'h00, SEW8, 32'h0, 0));
    // pair: address/SEW taken from the low half
    tbl.push_back(mk(0,1,0, 64'h0000_0000_1122_3344, 8'h0F, SEW32, 32'h10, 0,0, 0, 64'h0, 8'h00, SEW8, 32'h0, 1));
    tbl.push_back(mk(0,1,1, 64'hAABB_CCDD_0000_0000, 8'hF0, SEW16, 32'h99, 0,0,
                     1, 64'hAABB_CCDD_1122_3344, 8'hFF, SEW32, 32'h10, 0));
    // gap restart
    tbl.push_back(mk(0,1,0, 64'h0000_0000_1111_1111, 8'h0F, SEW8, 32'h4, 0,0, 0, 64'h0, 8'h00, SEW8, 32'h0, 1));
    tbl.push_back(idle(1));
    tbl.push_back(idle(1));
    tbl.push_back(idle(1));
    tbl.push_back(mk(0,1,0, 64'h0000_0000_2222_2222, 8'h0F, SEW16, 32'h5, 0,0,
                     1, 64'h0000_0000_1111_1111, 8'h0F, SEW8, 32'h4, 1));
    tbl.push_back(mk(0,1,1, 64'h3333_3333_0000_0000, 8'hF0, SEW8, 32'h77, 0,0,
                     1, 64'h3333_3333_2222_2222, 8'hFF, SEW16, 32'h5, 0));
    // last on a low half from EMPTY
    tbl.push_back(mk(0,1,0, 64'h0000_0000_DEAD_BEEF, 8'h03, SEW64, 32'h30, 1,0,
                     1, 64'h0000_0000_DEAD_BEEF, 8'h03, SEW64, 32'h30, 0));
    tbl.push_back(idle(0));
    // HOLD then a low half with last: two partials via FLUSH
    tbl.push_back(mk(0,1,0, 64'h0000_0000_AAAA_AAAA, 8'h0F, SEW32, 32'h8, 0,0, 0, 64'h0, 8'h00, SEW8, 32'h0, 1));
    tbl.push_back(mk(0,1,0, 64'h0000_0000_BBBB_BBBB, 8'h0C, SEW32, 32'h9, 1,0,
                     1, 64'h0000_0000_AAAA_AAAA, 8'h0F, SEW32, 32'h8, 1));
    tbl.push_back(mk(0,0,0, 64'h0, 8'h00, SEW8, 32'h0, 0,0,
                     1, 64'h0000_0000_BBBB_BBBB, 8'h0C, SEW32, 32'h9, 0));
    tbl.push_back(idle(0));
    // orphan high half
    tbl.push_back(mk(0,1,1, 64'h5555_5555_0000_0000, 8'hC0, SEW16, 32'h20, 0,0,
                     1, 64'h5555_5555_0000_0000, 8'hC0, SEW16, 32'h20, 0));
    // unselected half of data and be must be dropped
    tbl.push_back(mk(0,1,0, 64'hFFFF_FFFF_0123_4567, 8'hFF, SEW8, 32'h34, 1,0,
                     1, 64'h0000_0000_0123_4567, 8'h0F, SEW8, 32'h34, 0));
    tbl.push_back(idle(0));
    // explicit flush in HOLD
    tbl.push_back(mk(0,1,0, 64'h0000_0000_0BAD_F00D, 8'h0F, SEW8, 32'h40, 0,0, 0, 64'h0, 8'h00, SEW8, 32'h0, 1));
    tbl.push_back(idle(1));
    tbl.push_back(mk(0,0,0, 64'h0, 8'h00, SEW8, 32'h0, 0,1,
                     1, 64'h0000_0000_0BAD_F00D, 8'h0F, SEW8, 32'h40, 0));
    // flush together with a low half in EMPTY: emitted rather than held
    tbl.push_back(mk(0,1,0, 64'h0000_0000_0000_CAFE, 8'h0F, SEW16, 32'h44, 0,1,
                     1, 64'h0000_0000_0000_CAFE, 8'h0F, SEW16, 32'h44, 0));
    // in_last on the completing high half has no extra effect
    tbl.push_back(mk(0,1,0, 64'h0000_0000_0000_0001, 8'h0F, SEW8, 32'h50, 0,0, 0, 64'h0, 8'h00, SEW8, 32'h0, 1));
    tbl.push_back(mk(0,1,1, 64'h0000_0002_0000_0000, 8'hF0, SEW64, 32'h51, 1,0,
                     1, 64'h0000_0002_0000_0001, 8'hFF, SEW8, 32'h50, 0));
    tbl.push_back(idle(0));
    // orphan high half with junk in the low half
    tbl.push_back(mk(0,1,1, 64'h1234_5678_FFFF_FFFF, 8'hFF, SEW32, 32'h70, 0,0,
                     1, 64'h1234_5678_0000_0000, 8'hF0, SEW32, 32'h70, 0));

    foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

    // reset mid-HOLD: held half discarded, later high half is an orphan
    apply("rsthold cap", mk(0,1,0, 64'h0000_0000_7777_7777, 8'h0F, SEW32, 32'h58, 0,0,
                            0, 64'h0, 8'h00, SEW8, 32'h0, 1));
    apply("rsthold rst", mk(1,0,0, 64'h0, 8'h00, SEW8, 32'h0, 0,0,
                            0, 64'h0, 8'h00, SEW8, 32'h0, 0));
    apply("rsthold hi",  mk(0,1,1, 64'h9999_9999_0000_0000, 8'hF0, SEW64, 32'h60, 0,0,
                            1, 64'h9999_9999_0000_0000, 8'hF0, SEW64, 32'h60, 0));

    // reset mid-FLUSH: queued partial never appears
    apply("rstflush a",  mk(0,1,0, 64'h0000_0000_0A0A_0A0A, 8'h0F, SEW8, 32'h8, 0,0,
                            0, 64'h0, 8'h00, SEW8, 32'h0, 1));
    apply("rstflush b",  mk(0,1,0, 64'h0000_0000_0B0B_0B0B, 8'h0F, SEW8, 32'h9, 1,0,
                            1, 64'h0000_0000_0A0A_0A0A, 8'h0F, SEW8, 32'h8, 1));
    apply("rstflush rst", mk(1,0,0, 64'h0, 8'h00, SEW8, 32'h0, 0,0,
                            0, 64'h0, 8'h00, SEW8, 32'h0, 0));
    apply("rstflush idle", idle(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
